csr_access_ctrl: RTL and testbench
==================================

// Module: csr_access_ctrl
// PURPOSE
// - Initiator side of the machine-mode CSR file port.
// - Takes Zicsr instructions decoded in ID and computes the write value (RW/RS/RC and immediate forms) from CSR read data.
// - Carries each access down an internal EX/MEM/WB shadow pipeline and drives the WB-stage CSR write port.
// - Stalls ID on CSR read-after-write hazards and flags illegal writes to read-only CSRs as traps (mcause 2).
// PARAMETERS
// - PIPE_DEPTH  3   stages between ID issue and the WB write port, minimum 1.
// - RO_MASK     2'b11   value of addr[11:10] that marks a CSR read-only.
// PORTS
// - clk_i             in   1   clock
// - rst_ni            in   1   asynchronous active-low reset
// - id_valid_i        in   1   ID holds a CSR instruction
// - id_funct3_i       in   3   001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
// - id_csr_addr_i     in   12  CSR address
// - id_rs1_idx_i      in   5   rs1 index, or zimm for the immediate forms
// - id_rs1_data_i     in   32  rs1 value
// - id_rd_nz_i        in   1   rd != x0
// - csr_rdata_i       in   32  CSR file read data for id_csr_addr_i (combinational)
// - pipe_adv_i        in   1   pipeline advances this cycle
// - flush_i           in   1   kill all entries not yet in the WB stage
// - id_stall_o        out  1   hold ID: hazard present
// - id_rd_data_o      out  32  old CSR value for rd
// - wb_valid_o        out  1   WB slot holds a CSR access
// - wb_is_csr_write_o out  1   write enable toward the CSR file
// - wb_is_csr_read_o  out  1   rd != x0 at WB
// - wb_csr_addr_o     out  12  write address
// - wb_csr_wdata_o    out  32  write data
// - wb_illegal_o      out  1   illegal access trap request at WB
// - wb_trap_mcause_o  out  32  32'd2 when wb_illegal_o is set, else 0
// BEHAVIOUR
// - Reset: asynchronous, active-low; clk_i single clock.
//   - All stage valids clear; every output is 0 while rst_ni is low and after release.
// - Write enable at ID (we):
//   - RW/RWI: always 1.
//   - RS/RC/RSI/RCI: 1 only when rs1_idx/zimm != 0.
// - Source operand: src = RW/RS/RC ? rs1_data : {27'b0, zimm}.
// - Write data: RW -> src; RS -> old | src; RC -> old & ~src; old = csr_rdata_i.
// - Illegal access: we && addr[11:10] == RO_MASK.
//   - The entry travels with we forced to 0 and illegal = 1.
// - Issue: an entry {we, rd_nz, addr, wdata, illegal} enters stage 0 when id_valid_i && !id_stall_o && pipe_adv_i.
// - Advance: when pipe_adv_i = 1, all stages shift by one; when 0, every stage holds.
// - Latency: exactly PIPE_DEPTH advancing cycles from issue to WB outputs.
//   - Each WB output is valid for one advancing cycle.
// - Hazard:
//   - id_stall_o = id_valid_i && any valid stage has we = 1 and an address equal to id_csr_addr_i.
//   - MINSTRET/MCYCLE(H) reads never stall.
// - id_rd_data_o = csr_rdata_i whenever not stalled; 0 when id_funct3_i is invalid.
// - flush_i:
//   - Clears the valid bit of stages 0..PIPE_DEPTH-2 on the next edge.
//   - The WB stage completes unaffected.
//   - An ID issue in the same cycle is dropped.
//   - flush_i has priority over pipe_adv_i for the cleared stages.
// - Simultaneous retire and issue to the same address: stalls this cycle; released the cycle after the WB write.
// - Invalid funct3 (000, 100): no issue; id_stall_o = 0.
// - Reset asserted mid-operation: all in-flight entries are discarded; no partial write reaches WB.
// CONFIGURATION
// - Macro: CSR_ACCESS_FWD_EN.
// - With the macro defined:
//   - No hazard stall.
//   - The ID old value is taken from the youngest in-flight matching entry with we = 1 (wdata bypass).
//   - id_stall_o is tied 0.
// - Without the macro: stall behaviour exactly as described above.
// TESTING
// - CSRRW x5, mscratch, rs1 = 32'hDEAD_BEEF -> after 3 advancing cycles: wb_csr_addr_o = 12'h340, wb_csr_wdata_o = 32'hDEAD_BEEF, wb_is_csr_write_o = 1.
// - CSRRS mtvec with rs1 = x0, old = 32'h100 -> wb_is_csr_write_o = 0, wb_is_csr_read_o = 1, id_rd_data_o = 32'h100.
// - CSRRC old = 32'hFF, rs1 = 32'h0F -> wb_csr_wdata_o = 32'hF0.
// - CSRRSI zimm = 5, old = 32'h8 -> wb_csr_wdata_o = 32'hD.
// - CSRRW to mcycle (12'hB00 -> addr[11:10] = 2'b10, legal) vs. 12'hC00 -> wb_illegal_o = 1, wb_trap_mcause_o = 2, wb_is_csr_write_o = 0.
// - Back-to-back CSRRW mepc, then CSRRS mepc:
//   - Without CSR_ACCESS_FWD_EN: id_stall_o high for 3 cycles.
//   - With CSR_ACCESS_FWD_EN: zero stall, id_rd_data_o = first wdata.
// - flush_i with entries in stages 0 and 1 -> no WB write for either; an entry already at WB still writes.
// - rst_ni low mid-stream -> all outputs 0 immediately; no WB write after release.

Source files
------------

// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: ID-side request, CSR read data, pipeline control and
// WB-stage CSR write port of the CSR access controller, bundled as one port.
// master: the core side driving ID/pipeline control; slave: csr_access_ctrl.
interface csr_access_ctrl_if;
   // ID stage request
   logic        id_valid_i;
   logic [2:0]  id_funct3_i;
   logic [11:0] id_csr_addr_i;
   logic [4:0]  id_rs1_idx_i;
   logic [31:0] id_rs1_data_i;
   logic        id_rd_nz_i;
   logic [31:0] csr_rdata_i;
   // pipeline control
   logic        pipe_adv_i;
   logic        flush_i;
   // ID stage response
   logic        id_stall_o;
   logic [31:0] id_rd_data_o;
   // WB stage write port
   logic        wb_valid_o;
   logic        wb_is_csr_write_o;
   logic        wb_is_csr_read_o;
   logic [11:0] wb_csr_addr_o;
   logic [31:0] wb_csr_wdata_o;
   logic        wb_illegal_o;
   logic [31:0] wb_trap_mcause_o;

   modport master (
      output id_valid_i, id_funct3_i, id_csr_addr_i, id_rs1_idx_i, id_rs1_data_i,
             id_rd_nz_i, csr_rdata_i, pipe_adv_i, flush_i,
      input  id_stall_o, id_rd_data_o, wb_valid_o, wb_is_csr_write_o, wb_is_csr_read_o,
             wb_csr_addr_o, wb_csr_wdata_o, wb_illegal_o, wb_trap_mcause_o
   );

   modport slave (
      input  id_valid_i, id_funct3_i, id_csr_addr_i, id_rs1_idx_i, id_rs1_data_i,
             id_rd_nz_i, csr_rdata_i, pipe_adv_i, flush_i,
      output id_stall_o, id_rd_data_o, wb_valid_o, wb_is_csr_write_o, wb_is_csr_read_o,
             wb_csr_addr_o, wb_csr_wdata_o, wb_illegal_o, wb_trap_mcause_o
   );
endinterface

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: initiator side of the machine-mode CSR file port.
// Decodes Zicsr accesses at ID, computes the write value from the CSR read
// data, carries each access through a PIPE_DEPTH-deep shadow pipeline and
// drives the CSR write port from the last (WB) stage. Writes to read-only
// CSRs (addr[11:10] == RO_MASK) travel as illegal, non-writing entries.
// Optional feature: define CSR_ACCESS_FWD_EN to replace the read-after-write
// stall with a bypass of the youngest in-flight write to the same CSR.
// PIPE_DEPTH must be at least 1; with PIPE_DEPTH == 1 stage 0 is the WB stage.
module csr_access_ctrl #(
   parameter int         PIPE_DEPTH = 3,
   parameter logic [1:0] RO_MASK    = 2'b11
) (
   input logic              clk_i,
   input logic              rst_ni,
   csr_access_ctrl_if.slave bus
);

   localparam int STAGES = PIPE_DEPTH - 1;

   typedef struct packed {
      logic        we;
      logic        rd_nz;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        illegal;
   } csr_entry_t;

   logic       [STAGES:0] vld_pipe;
   csr_entry_t [STAGES:0] pipe_q;
   csr_entry_t            id_entry;
   csr_entry_t            wb_q;

   logic        f3_ok;
   logic        we_raw;
   logic        ro_hit;
   logic        stall;
   logic        issue;
   logic [31:0] src;
   logic [31:0] old_val;
   logic [31:0] wdata;

   // 000 and 100 are not CSR accesses: no issue, no stall, no read data
   assign f3_ok = (bus.id_funct3_i[1:0] != 2'b00);

`ifdef CSR_ACCESS_FWD_EN
   logic        fwd_hit;
   logic [31:0] fwd_data;

   // Youngest in-flight write to the same CSR wins: scan oldest to youngest
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = STAGES; i >= 0; i--) begin
         if (vld_pipe[i] && pipe_q[i].we && (pipe_q[i].addr == bus.id_csr_addr_i)) begin
            fwd_hit  = 1'b1;
            fwd_data = pipe_q[i].wdata;
         end
      end
   end

   assign old_val = fwd_hit ? fwd_data : bus.csr_rdata_i;
   assign stall   = 1'b0;
`else
   logic raw_hit;
   logic ctr_addr;

   // Any in-flight write (WB stage included) to the CSR being read at ID
   always_comb begin
      raw_hit = 1'b0;
      for (int i = 0; i <= STAGES; i++) begin
         if (vld_pipe[i] && pipe_q[i].we && (pipe_q[i].addr == bus.id_csr_addr_i))
            raw_hit = 1'b1;
      end
   end

   // Free-running counters change every cycle anyway, so ordering against an
   // in-flight write buys nothing; their reads never wait
   assign ctr_addr = (bus.id_csr_addr_i == 12'hB00) || (bus.id_csr_addr_i == 12'hB02) ||
                     (bus.id_csr_addr_i == 12'hB80) || (bus.id_csr_addr_i == 12'hB82);

   assign old_val = bus.csr_rdata_i;
   assign stall   = bus.id_valid_i && f3_ok && raw_hit && !ctr_addr;
`endif

   // ID decode: write enable, operand select, RW/RS/RC write value, RO check
   always_comb begin
      src    = bus.id_funct3_i[2] ? {27'b0, bus.id_rs1_idx_i} : bus.id_rs1_data_i;
      we_raw = (bus.id_funct3_i[1:0] == 2'b01) || (bus.id_rs1_idx_i != 5'd0);
      case (bus.id_funct3_i[1:0])
         2'b10:   wdata = old_val | src;
         2'b11:   wdata = old_val & ~src;
         default: wdata = src;
      endcase
      ro_hit           = f3_ok && we_raw && (bus.id_csr_addr_i[11:10] == RO_MASK);
      id_entry.we      = we_raw && !ro_hit;
      id_entry.rd_nz   = bus.id_rd_nz_i;
      id_entry.addr    = bus.id_csr_addr_i;
      id_entry.wdata   = wdata;
      id_entry.illegal = ro_hit;
   end

   // A flush in the same cycle drops the ID access along with stages 0..N-2
   assign issue = bus.id_valid_i && f3_ok && !stall && bus.pipe_adv_i && !bus.flush_i;

   // Shadow pipeline: shift on advance, hold otherwise; flush kills every
   // stage short of WB, and whatever would move into WB from a killed stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe <= '0;
         pipe_q   <= '0;
      end else begin
         if (bus.pipe_adv_i) begin
            vld_pipe[0] <= issue;
            pipe_q[0]   <= id_entry;
         end else if (bus.flush_i && (STAGES > 0)) begin
            vld_pipe[0] <= 1'b0;
         end
         for (int i = 1; i <= STAGES; i++) begin
            if (bus.pipe_adv_i) begin
               vld_pipe[i] <= vld_pipe[i-1] && !bus.flush_i;
               pipe_q[i]   <= pipe_q[i-1];
            end else if (bus.flush_i && (i < STAGES)) begin
               vld_pipe[i] <= 1'b0;
            end
         end
      end
   end

   // ID response is forced quiet in reset and while the access is held
   assign bus.id_stall_o   = rst_ni && stall;
   assign bus.id_rd_data_o = (rst_ni && f3_ok && !stall) ? old_val : '0;

   // WB write port straight from the last stage, masked by its valid bit
   assign wb_q                  = pipe_q[STAGES];
   assign bus.wb_valid_o        = vld_pipe[STAGES];
   assign bus.wb_is_csr_write_o = vld_pipe[STAGES] && wb_q.we;
   assign bus.wb_is_csr_read_o  = vld_pipe[STAGES] && wb_q.rd_nz;
   assign bus.wb_csr_addr_o     = vld_pipe[STAGES] ? wb_q.addr  : '0;
   assign bus.wb_csr_wdata_o    = vld_pipe[STAGES] ? wb_q.wdata : '0;
   assign bus.wb_illegal_o      = vld_pipe[STAGES] && wb_q.illegal;
   assign bus.wb_trap_mcause_o  = (vld_pipe[STAGES] && wb_q.illegal) ? 32'd2 : 32'd0;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: table of single Zicsr accesses plus hand-written
// sequences for hold, hazard, counter/invalid, flush and mid-stream reset.
// Expected WB entries go into a scoreboard queue when driven and are popped
// when the DUT retires an entry from WB.
module tb_csr_access_ctrl;

   logic clk_i = 1'b0;
   logic rst_ni;

   csr_access_ctrl_if bus ();

   csr_access_ctrl #(
      .PIPE_DEPTH (3),
      .RO_MASK    (2'b11)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk_i = ~clk_i;

`ifdef CSR_ACCESS_FWD_EN
   localparam logic        EXP_HOLD_STALL = 1'b0;
   localparam logic [31:0] EXP_HOLD_RD    = 32'h1234;
   localparam int          EXP_HAZ_STALLS = 0;
   localparam logic [31:0] HAZ_OLD        = 32'h11;
`else
   localparam logic        EXP_HOLD_STALL = 1'b1;
   localparam logic [31:0] EXP_HOLD_RD    = 32'h0;
   localparam int          EXP_HAZ_STALLS = 3;
   localparam logic [31:0] HAZ_OLD        = 32'hCAFE_0000;
`endif

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        ill;
   } wb_exp_t;

   typedef struct {
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [4:0]  idx;
      logic [31:0] rs1;
      logic        rd_nz;
      logic [31:0] old;
      logic [31:0] exp_rd;
      logic        issue;
      wb_exp_t     exp_wb;
   } vec_t;

   wb_exp_t sb_q[$];
   vec_t    vecs[15];
   int      checks = 0;
   int      errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic wb_exp_t mk(input logic wr, input logic rd, input logic [11:0] a,
                                  input logic [31:0] wd, input logic ill);
      wb_exp_t e;
      e.wr = wr; e.rd = rd; e.addr = a; e.wdata = wd; e.ill = ill;
      return e;
   endfunction

   function automatic vec_t mkv(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                                input logic [31:0] rs1, input logic rd_nz, input logic [31:0] old,
                                input logic [31:0] exp_rd, input logic issue, input logic wr,
                                input logic [31:0] wd, input logic ill);
      vec_t v;
      v.f3 = f3; v.addr = a; v.idx = idx; v.rs1 = rs1; v.rd_nz = rd_nz; v.old = old;
      v.exp_rd = exp_rd; v.issue = issue; v.exp_wb = mk(wr, rd_nz, a, wd, ill);
      return v;
   endfunction

   task automatic drive(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                        input logic [31:0] d, input logic rd_nz, input logic [31:0] old);
      bus.id_valid_i    = 1'b1;
      bus.id_funct3_i   = f3;
      bus.id_csr_addr_i = a;
      bus.id_rs1_idx_i  = idx;
      bus.id_rs1_data_i = d;
      bus.id_rd_nz_i    = rd_nz;
      bus.csr_rdata_i   = old;
   endtask

   function automatic logic [127:0] all_outs();
      return {15'b0, bus.id_stall_o, bus.id_rd_data_o, bus.wb_valid_o, bus.wb_is_csr_write_o,
              bus.wb_is_csr_read_o, bus.wb_csr_addr_o, bus.wb_csr_wdata_o, bus.wb_illegal_o,
              bus.wb_trap_mcause_o};
   endfunction

   // Scoreboard: an entry retires from WB on a negedge where the pipe advances
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (bus.wb_valid_o && bus.pipe_adv_i) begin
            if (sb_q.size() == 0) begin
               chk("wb_unexpected", bus.wb_valid_o, 1'b0);
            end else begin
               wb_exp_t e;
               e = sb_q.pop_front();
               chk("wb_entry",
                   {bus.wb_is_csr_write_o, bus.wb_is_csr_read_o, bus.wb_csr_addr_o,
                    bus.wb_csr_wdata_o, bus.wb_illegal_o, bus.wb_trap_mcause_o},
                   {e.wr, e.rd, e.addr, e.wdata, e.ill, (e.ill ? 32'd2 : 32'd0)});
            end
         end else if (!bus.wb_valid_o) begin
            chk("wb_idle", {bus.wb_is_csr_write_o, bus.wb_is_csr_read_o, bus.wb_illegal_o,
                            bus.wb_trap_mcause_o}, 35'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      bit issued;

      vecs[0]  = mkv(3'b001, 12'h340, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      vecs[1]  = mkv(3'b010, 12'h305, 5'd0, 32'h0,         1'b1, 32'h100,       32'h100,       1'b1, 1'b0, 32'h100,       1'b0);
      vecs[2]  = mkv(3'b011, 12'h300, 5'd3, 32'h0F,        1'b1, 32'hFF,        32'hFF,        1'b1, 1'b1, 32'hF0,        1'b0);
      vecs[3]  = mkv(3'b110, 12'h341, 5'd5, 32'hFFFF_FFFF, 1'b1, 32'h8,         32'h8,         1'b1, 1'b1, 32'hD,         1'b0);
      vecs[4]  = mkv(3'b001, 12'hB00, 5'd1, 32'h55,        1'b1, 32'h0,         32'h0,         1'b1, 1'b1, 32'h55,        1'b0);
      vecs[5]  = mkv(3'b001, 12'hC00, 5'd1, 32'h55,        1'b1, 32'h9,         32'h9,         1'b1, 1'b0, 32'h55,        1'b1);
      vecs[6]  = mkv(3'b101, 12'h342, 5'd0, 32'hFFFF,      1'b1, 32'h3,         32'h3,         1'b1, 1'b1, 32'h0,         1'b0);
      vecs[7]  = mkv(3'b111, 12'h343, 5'd0, 32'h0,         1'b1, 32'hABCD,      32'hABCD,      1'b1, 1'b0, 32'hABCD,      1'b0);
      vecs[8]  = mkv(3'b110, 12'hC01, 5'd0, 32'h0,         1'b1, 32'h7,         32'h7,         1'b1, 1'b0, 32'h7,         1'b0);
      vecs[9]  = mkv(3'b010, 12'hC02, 5'd1, 32'h1,         1'b1, 32'h10,        32'h10,        1'b1, 1'b0, 32'h11,        1'b1);
      vecs[10] = mkv(3'b001, 12'h344, 5'd2, 32'hA5,        1'b0, 32'h1,         32'h1,         1'b1, 1'b1, 32'hA5,        1'b0);
      vecs[11] = mkv(3'b000, 12'h345, 5'd1, 32'h1,         1'b1, 32'h99,        32'h0,         1'b0, 1'b0, 32'h0,         1'b0);
      vecs[12] = mkv(3'b100, 12'h345, 5'd1, 32'h1,         1'b1, 32'h99,        32'h0,         1'b0, 1'b0, 32'h0,         1'b0);
      vecs[13] = mkv(3'b011, 12'h7C0, 5'd4, 32'hFFFF_0000, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_FFFF, 1'b0);
      vecs[14] = mkv(3'b111, 12'hC03, 5'd1, 32'h0,         1'b1, 32'hF,         32'hF,         1'b1, 1'b0, 32'hE,         1'b1);

      // Reset state with an active ID request present
      rst_ni         = 1'b0;
      bus.pipe_adv_i = 1'b1;
      bus.flush_i    = 1'b0;
      drive(3'b001, 12'h340, 5'd1, 32'h1, 1'b1, 32'hFFFF_FFFF);
      #3;
      chk("reset_outputs", all_outs(), 128'd0);
      @(posedge clk_i); #1;
      bus.id_valid_i  = 1'b0;
      bus.id_funct3_i = 3'b000;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_reset_outputs", all_outs(), 128'd0);

      // Table: one access per cycle, distinct addresses
      foreach (vecs[i]) begin
         @(posedge clk_i); #1;
         drive(vecs[i].f3, vecs[i].addr, vecs[i].idx, vecs[i].rs1, vecs[i].rd_nz, vecs[i].old);
         if (vecs[i].issue) sb_q.push_back(vecs[i].exp_wb);
         @(negedge clk_i);
         chk($sformatf("vec%0d_stall", i), bus.id_stall_o, 1'b0);
         chk($sformatf("vec%0d_rd", i), bus.id_rd_data_o, vecs[i].exp_rd);
      end
      @(posedge clk_i); #1;
      bus.id_valid_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #1;
      chk("table_drain", sb_q.size(), 0);

      // Hold: pipeline frozen four cycles, latency counts advancing edges only
      drive(3'b001, 12'h347, 5'd1, 32'h1234, 1'b1, 32'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 12'h347, 32'h1234, 1'b0));
      @(posedge clk_i); #1;
      bus.pipe_adv_i = 1'b0;
      drive(3'b010, 12'h347, 5'd2, 32'h1, 1'b1, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk("hold_wb_valid", bus.wb_valid_o, 1'b0);
         chk("hold_stall", bus.id_stall_o, EXP_HOLD_STALL);
         chk("hold_rd", bus.id_rd_data_o, EXP_HOLD_RD);
         @(posedge clk_i); #1;
      end
      bus.id_valid_i = 1'b0;
      bus.pipe_adv_i = 1'b1;
      @(negedge clk_i);
      chk("latency_adv1", bus.wb_valid_o, 1'b0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("latency_adv2", bus.wb_valid_o, 1'b0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("latency_adv3", bus.wb_valid_o, 1'b1);
      repeat (2) @(posedge clk_i);
      #1;

      // Back-to-back CSRRW mepc then CSRRS mepc
      drive(3'b001, 12'h341, 5'd1, 32'hCAFE_0000, 1'b1, 32'h11);
      sb_q.push_back(mk(1'b1, 1'b1, 12'h341, 32'hCAFE_0000, 1'b0));
      stalls = 0;
      issued = 1'b0;
      for (int k = 0; k < 8 && !issued; k++) begin
         @(posedge clk_i); #1;
         drive(3'b010, 12'h341, 5'd2, 32'h1, 1'b1, HAZ_OLD);
         @(negedge clk_i);
         if (bus.id_stall_o) begin
            stalls++;
            chk("haz_rd_stalled", bus.id_rd_data_o, 32'h0);
         end else begin
            issued = 1'b1;
            chk("haz_rd", bus.id_rd_data_o, 32'hCAFE_0000);
            sb_q.push_back(mk(1'b0 | 1'b1, 1'b1, 12'h341, 32'hCAFE_0001, 1'b0));
         end
      end
      @(posedge clk_i); #1;
      bus.id_valid_i = 1'b0;
      chk("haz_issued", issued, 1'b1);
      chk("haz_stall_cycles", stalls, EXP_HAZ_STALLS);
      repeat (4) @(posedge clk_i);
      #1;

      // Invalid funct3 and counter reads never stall
      drive(3'b001, 12'h346, 5'd1, 32'h5, 1'b1, 32'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 12'h346, 32'h5, 1'b0));
      @(posedge clk_i); #1;
      drive(3'b000, 12'h346, 5'd1, 32'h5, 1'b1, 32'h44);
      @(negedge clk_i);
      chk("inv_f3_stall", bus.id_stall_o, 1'b0);
      chk("inv_f3_rd", bus.id_rd_data_o, 32'h0);
      @(posedge clk_i); #1;
      drive(3'b001, 12'hB00, 5'd1, 32'h77, 1'b1, 32'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 12'hB00, 32'h77, 1'b0));
      @(posedge clk_i); #1;
      drive(3'b010, 12'hB00, 5'd0, 32'h0, 1'b1, 32'h77);
      sb_q.push_back(mk(1'b0, 1'b1, 12'hB00, 32'h77, 1'b0));
      @(negedge clk_i);
      chk("mcycle_stall", bus.id_stall_o, 1'b0);
      chk("mcycle_rd", bus.id_rd_data_o, 32'h77);
      @(posedge clk_i); #1;
      bus.id_valid_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      chk("seq_drain", sb_q.size(), 0);

      // Flush: A at WB completes, B/C in stages 1/0 and same-cycle D dropped
      drive(3'b001, 12'h350, 5'd1, 32'hA, 1'b1, 32'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 12'h350, 32'hA, 1'b0));
      @(posedge clk_i); #1;
      drive(3'b001, 12'h351, 5'd1, 32'hB, 1'b1, 32'h0);
      @(posedge clk_i); #1;
      drive(3'b001, 12'h352, 5'd1, 32'hC, 1'b1, 32'h0);
      @(posedge clk_i); #1;
      drive(3'b001, 12'h353, 5'd1, 32'hD, 1'b1, 32'h0);
      bus.flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_wb_addr", bus.wb_csr_addr_o, 12'h350);
      @(posedge clk_i); #1;
      bus.flush_i    = 1'b0;
      bus.id_valid_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         chk("flush_no_wb", bus.wb_valid_o, 1'b0);
      end
      chk("flush_drain", sb_q.size(), 0);

      // Reset mid-stream: in-flight X/Y discarded, outputs zero at once
      @(posedge clk_i); #1;
      drive(3'b001, 12'h360, 5'd1, 32'h1, 1'b1, 32'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 12'h360, 32'h1, 1'b0));
      @(posedge clk_i); #1;
      drive(3'b001, 12'h361, 5'd1, 32'h2, 1'b1, 32'h0);
      sb_q.push_back(mk(1'b1, 1'b1, 12'h361, 32'h2, 1'b0));
      @(posedge clk_i); #1;
      drive(3'b001, 12'h362, 5'd1, 32'h3, 1'b1, 32'h5A);
      rst_ni = 1'b0;
      #1;
      chk("rst_mid_outputs", all_outs(), 128'd0);
      sb_q.delete();
      @(posedge clk_i); #1;
      bus.id_valid_i  = 1'b0;
      bus.id_funct3_i = 3'b000;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         chk("rst_no_wb", bus.wb_valid_o, 1'b0);
      end

      chk("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
